// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial: digit-serial packed-BCD subtractor, diff = a - b - bin,
// one digit per clock, least-significant digit first.
// Optional magnitude mode: define BCD_MAGNITUDE_EN to have a negative result
// re-complemented into its magnitude, with the neg output set.
//
// Handshake: start is sampled only while idle. The accept edge latches a/b/bin.
// busy is high from that edge until the result is ready. done is then a single-cycle
// pulse with busy low. diff/bout/err/neg update on that pulse and hold until the
// next one. A start seen while busy or during done is dropped, not queued.
module bcd_subtractor_serial #(
  parameter int NDIGITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NDIGITS-1:0] a,
  input  logic [4*NDIGITS-1:0] b,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NDIGITS-1:0] diff,
  output logic                 bout,
  output logic                 err,
  output logic                 neg
);

  localparam int W  = 4 * NDIGITS;
  localparam int KW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

`ifdef BCD_MAGNITUDE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1, S_DONE = 2'd2, S_COMP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1, S_DONE = 2'd2} state_e;
`endif

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [KW-1:0]   k_q, k_d;
  logic            borrow_q, borrow_d;
  logic            err_acc_q, err_acc_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;
  logic            err_q, err_d;
`ifdef BCD_MAGNITUDE_EN
  logic            neg_q, neg_d;
`endif

  // Shared digit datapath
  logic [3:0]   op_a, op_b, digit;
  logic [4:0]   t;
  logic         t_neg, digit_bad, last_digit;
  logic [W-1:0] work_next;

  // Next-state, digit arithmetic and result capture
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    k_d       = k_q;
    borrow_d  = borrow_q;
    err_acc_d = err_acc_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    err_d     = err_q;
`ifdef BCD_MAGNITUDE_EN
    neg_d     = neg_q;
`endif

    // Operand select: SUB uses the latched digits, COMP computes 0 - work.
    op_a = a_q[k_q*4 +: 4];
    op_b = b_q[k_q*4 +: 4];
`ifdef BCD_MAGNITUDE_EN
    if (state_q == S_COMP) begin
      op_a = 4'd0;
      op_b = work_q[k_q*4 +: 4];
    end
`endif
    // 5-bit two's-complement difference; bit 4 set means the digit went negative.
    t          = {1'b0, op_a} - {1'b0, op_b} - {4'd0, borrow_q};
    t_neg      = t[4];
    digit      = t_neg ? (t[3:0] + 4'd10) : t[3:0];
    digit_bad  = (op_a > 4'd9) || (op_b > 4'd9);
    last_digit = (k_q == KW'(NDIGITS - 1));
    work_next  = work_q;
    work_next[k_q*4 +: 4] = digit;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          borrow_d  = bin;
          k_d       = '0;
          work_d    = '0;
          err_acc_d = 1'b0;
          state_d   = S_SUB;
        end
      end
      S_SUB: begin
        work_d    = work_next;
        borrow_d  = t_neg;
        err_acc_d = err_acc_q | digit_bad;
        k_d       = k_q + KW'(1);
        if (last_digit) begin
          k_d     = '0;
          state_d = S_DONE;
          diff_d  = err_acc_d ? '0 : work_next;
          bout_d  = err_acc_d ? 1'b0 : t_neg;
          err_d   = err_acc_d;
`ifdef BCD_MAGNITUDE_EN
          neg_d   = 1'b0;
          // Negative, valid result: recomplement before reporting.
          if (t_neg && !err_acc_d) begin
            state_d  = S_COMP;
            borrow_d = 1'b0;
            diff_d   = diff_q;
            bout_d   = bout_q;
            err_d    = err_q;
            neg_d    = neg_q;
          end
`endif
        end
      end
`ifdef BCD_MAGNITUDE_EN
      S_COMP: begin
        work_d   = work_next;
        borrow_d = t_neg;
        k_d      = k_q + KW'(1);
        if (last_digit) begin
          k_d     = '0;
          state_d = S_DONE;
          diff_d  = work_next;
          bout_d  = 1'b1;
          err_d   = 1'b0;
          neg_d   = 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, async active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      k_q       <= '0;
      borrow_q  <= 1'b0;
      err_acc_q <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BCD_MAGNITUDE_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      k_q       <= k_d;
      borrow_q  <= borrow_d;
      err_acc_q <= err_acc_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      err_q     <= err_d;
`ifdef BCD_MAGNITUDE_EN
      neg_q     <= neg_d;
`endif
    end
  end

`ifdef BCD_MAGNITUDE_EN
  assign busy = (state_q == S_SUB) || (state_q == S_COMP);
  assign neg  = neg_q;
`else
  assign busy = (state_q == S_SUB);
  assign neg  = 1'b0;
`endif
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial: directed and random checks of bcd_subtractor_serial
// against an integer-arithmetic reference model.
module tb_bcd_subtractor_serial;

  localparam int N = 2;
  localparam int W = 4 * N;
`ifdef BCD_MAGNITUDE_EN
  localparam bit MAG = 1'b1;
`else
  localparam bit MAG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, err, neg;
  logic [W-1:0] diff;

  int tests = 0;
  int fails = 0;

  // Clock / reset
  always #5 clk = ~clk;

  bcd_subtractor_serial #(.NDIGITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .err(err), .neg(neg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: convert digits to integers, subtract, map back to BCD.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo, output logic mer,
                       output logic mng, output int mlat);
    int av, bv, val, r, modv;
    logic [3:0] da, db;
    av = 0; bv = 0; modv = 1; mer = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      da = ma[4*i +: 4];
      db = mb[4*i +: 4];
      if (da > 4'd9 || db > 4'd9) mer = 1'b1;
      av = av * 10 + int'(da);
      bv = bv * 10 + int'(db);
      modv = modv * 10;
    end
    val = av - bv - int'(mbin);
    md = '0; mbo = 1'b0; mng = 1'b0; mlat = N + 1;
    if (!mer) begin
      if (val < 0) begin
        mbo = 1'b1;
        if (MAG) begin
          mng = 1'b1;
          r = -val;
          mlat = 2 * N + 1;
        end else begin
          r = val + modv;
        end
      end else begin
        r = val;
      end
      for (int i = 0; i < N; i++) begin
        md[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
  endtask

  // Driver: one full operation, checking handshake timing and results.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    logic [W-1:0] ed;
    logic eb, ee, en;
    int lat, cyc;
    logic [W-1:0] exp_q[$];
    model(ta, tb_v, tbin, ed, eb, ee, en, lat);
    exp_q.push_back(ed);
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    cyc = 1;
    check("busy_after_accept", 32'(busy), 32'(1));
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'(lat));
    check("diff", 32'(diff), 32'(exp_q.pop_front()));
    check("bout", 32'(bout), 32'(eb));
    check("err", 32'(err), 32'(ee));
    check("neg", 32'(neg), 32'(en));
    check("busy_in_done", 32'(busy), 32'(0));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'(0));
    check("diff_held", 32'(diff), 32'(ed));
  endtask

  logic [W-1:0] ra, rb;
  int done_cnt, done_at[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_bout", 32'(bout), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_neg", 32'(neg), 32'(0));
    rst_n = 1'b1;

    // Directed cases
    run_op(8'h50, 8'h49, 1'b1);
    run_op(8'h01, 8'h99, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h99, 8'h99, 1'b0);
    run_op(8'h0A, 8'h01, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h12, 8'h34, 1'b1);

    // Reset mid-SUB aborts; no done follows
    run_op(8'h01, 8'h99, 1'b0);
    @(negedge clk);
    a = 8'h42; b = 8'h17; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_diff", 32'(diff), 32'(0));
    check("midrst_bout", 32'(bout), 32'(0));
    check("midrst_err", 32'(err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (3 * N + 4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'(0));
    run_op(8'h42, 8'h17, 1'b0);

    // Back-to-back: start held high
    @(negedge clk);
    a = 8'h09; b = 8'h01; bin = 1'b1; start = 1'b1;
    for (int c = 1; c <= 3 * (N + 2); c++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(c);
        check("b2b_diff", 32'(diff), 32'(8'h07));
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(done_at.size()), 32'(3));
    for (int j = 0; j < done_at.size(); j++)
      check("b2b_spacing", 32'(done_at[j]), 32'(j * (N + 2) + N + 1));
    repeat (N + 3) @(negedge clk);

    // Random operands, mostly valid BCD with occasional bad digits
    for (int it = 0; it < 25; it++) begin
      for (int d = 0; d < N; d++) begin
        ra[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_subtractor_serial.md
Name: bcd_subtractor_serial

Overview:
- Digit-serial packed-BCD subtractor: computes diff = a - b - bin over NDIGITS BCD digits, one digit per clock, LSD first.
- Produces a borrow-out and flags any non-BCD input digit.
- Start/busy/done handshake; sits beside the combinational BCD adder in the decimal arithmetic datapath.
- Serves the inverse operation (subtraction) where area matters more than latency.

Parameters:
- NDIGITS, 2, number of packed BCD digits per operand (>=1); operand width is 4*NDIGITS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  4*NDIGITS  minuend, packed BCD, captured on accepted start
- b  input  4*NDIGITS  subtrahend, packed BCD, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse: results valid
- diff  output  4*NDIGITS  packed BCD result; held until the next completion
- bout  output  1  borrow-out (1 = a < b + bin); held
- err  output  1  any a/b digit > 9; held
- neg  output  1  magnitude-mode sign (macro only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, diff, bout, err, neg all 0; internal registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced. Outputs go to their reset values.
- IDLE: start=1 at edge T latches a, b, bin, sets digit index k=0 and borrow=bin, then moves to SUB. busy=1 from T.
- SUB: one digit per edge. Compute t = a[k] - b[k] - borrow as a 5-bit signed value.
  - If t < 0: digit = t + 10, borrow = 1.
  - Otherwise: digit = t, borrow = 0.
  - Write the digit into diff working register slot k, then k++.
  - After digit NDIGITS-1, move to DONE (or to COMP, see Optional Feature).
- Digit check: in SUB, if a[k] > 9 or b[k] > 9, the sticky err flag is set.
- DONE: lasts one cycle with done=1 and busy=0.
  - diff/bout/err output registers update on entry to DONE.
  - Outputs stay stable until the next DONE.
  - If err=1, diff and bout are forced to 0.
  - Next state: IDLE.
- Latency: done is high in the cycle following edge T+NDIGITS, where T is the accept edge.
- Throughput: a new start is accepted in the IDLE cycle after DONE, so the minimum start-to-start spacing is NDIGITS+2 cycles.
- start while busy or during DONE is ignored; it is not queued.
- Operand changes after the accept edge have no effect.
- Wrap-around: the result is modulo 10^NDIGITS. A negative true result yields its ten's complement with bout=1.

Optional Feature:
- Macro: BCD_MAGNITUDE_EN.
- With the macro defined:
  - If the final borrow after SUB is 1 and err=0, the FSM enters COMP instead of DONE.
  - COMP runs NDIGITS digit-serial cycles computing 0 - diff (same digit rule, initial borrow 0). This replaces diff with its magnitude.
  - neg is set to 1 and bout stays 1.
  - Latency in that case is 2*NDIGITS+1; the non-negative case is unchanged and has neg=0.
- Without the macro: no COMP state, neg is tied 0, and diff is always the ten's complement form.

Test Plan:
- Reset mid-SUB: pulse rst_n low during SUB -> busy/done/diff/bout/err all 0 immediately; no done pulse follows; next start behaves normally.
- a=0x50, b=0x49, bin=1 -> done at T+3; diff=0x00, bout=0, err=0.
- a=0x01, b=0x99, bin=0 -> diff=0x02, bout=1. With BCD_MAGNITUDE_EN: done at T+5, diff=0x98, neg=1.
- a=0x00, b=0x00, bin=1 -> diff=0x99, bout=1. With macro: diff=0x01, neg=1. Also a=0x99, b=0x99, bin=0 -> diff=0x00, bout=0, neg=0.
- a=0x0A, b=0x01 -> err=1, diff=0x00, bout=0, done asserted on normal schedule.
- Back-to-back: hold start=1 continuously with a=0x09, b=0x01, bin=1 -> diff=0x07 each time; starts accepted every NDIGITS+2 cycles; start during busy is ignored.
